// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: pointer code conversions and
// the depth of the read-side output buffer.
package fifo_pkg;

    localparam int BUF_DEPTH = 2;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down recovers the binary value.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int s = 1; s < 32; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry output buffer between the memory read port and the consumer.
// Entry e0 is always the head; a write and pop together at count 1 lands the new word in e0.
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  r_clk,
    input  logic                  r_rst_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] e0;
    logic [DATA_WIDTH-1:0] e1;

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            count <= 2'd0;
            e0    <= '0;
            e1    <= '0;
        end else begin
            if (wr && (count == 2'd0 || (count == 2'd1 && pop))) begin
                e0 <= wdata;
            end else if (pop && count == 2'd2) begin
                e0 <= e1;
            end
            if (wr && count == 2'd1 && !pop) begin
                e1 <= wdata;
            end
            count <= count + {1'b0, wr} - {1'b0, pop};
        end
    end

    assign head = e0;

    a_no_overflow: assert property (@(posedge r_clk) disable iff (!r_rst_n)
        !(wr && count == 2'(BUF_DEPTH)));

    a_no_underflow: assert property (@(posedge r_clk) disable iff (!r_rst_n)
        !(pop && count == 2'd0));

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: read pointer (binary/Gray),
// registered empty and level, memory read issue, and the output handshake.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  r_clk,
    input  logic                  r_rst_n,
    input  logic [ADDR_WIDTH:0]   sync_gr_w_ptr,
    output logic [ADDR_WIDTH:0]   gr_r_ptr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  r_en,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   r_level
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin;
    logic          inflight;
    logic          pop;
    logic [1:0]    buf_cnt;
    logic [2:0]    credit;

    // Handshake: a word transfers on every r_clk edge where out_valid and
    // out_ready are both high; out_valid never depends on out_ready, and
    // out_data holds steady while out_valid is high and out_ready is low.
    assign out_valid = (buf_cnt != 2'd0);
    assign pop       = out_valid & out_ready;

    // Words buffered plus in flight after this cycle's pop must leave room for one more.
    assign credit = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
    assign r_en   = !empty && (credit < 3'(BUF_DEPTH));

    assign rbin_next  = rbin + PW'(r_en);
    assign rgray_next = PW'(bin2gray(32'(rbin_next)));
    assign wbin       = PW'(gray2bin(32'(sync_gr_w_ptr)));
    assign r_addr     = rbin[ADDR_WIDTH-1:0];

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            rbin     <= '0;
            gr_r_ptr <= '0;
            empty    <= 1'b1;
            inflight <= 1'b0;
            r_level  <= '0;
        end else begin
            rbin     <= rbin_next;
            gr_r_ptr <= rgray_next;
            empty    <= (rgray_next == sync_gr_w_ptr);
            inflight <= r_en;
            r_level  <= wbin - rbin;
        end
    end

    fifo_out_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_buf (
        .r_clk  (r_clk),
        .r_rst_n(r_rst_n),
        .wr     (inflight),
        .wdata  (r_data),
        .pop    (pop),
        .count  (buf_cnt),
        .head   (out_data)
    );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a word-level model of the FIFO read side checked
// every cycle, plus hand-computed expectations for each directed scenario.
module tb_fifo_rd_ctrl;

    localparam int AW = 3;
    localparam int DW = 8;

    logic          r_clk = 1'b0;
    logic          r_rst_n;
    logic [AW:0]   sync_gr_w_ptr;
    logic [AW:0]   gr_r_ptr;
    logic [AW-1:0] r_addr;
    logic          r_en;
    logic [DW-1:0] r_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          empty;
    logic [AW:0]   r_level;

    fifo_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .r_clk        (r_clk),
        .r_rst_n      (r_rst_n),
        .sync_gr_w_ptr(sync_gr_w_ptr),
        .gr_r_ptr     (gr_r_ptr),
        .r_addr       (r_addr),
        .r_en         (r_en),
        .r_data       (r_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .empty        (empty),
        .r_level      (r_level)
    );

    // ---------------- clock / reset ----------------
    always #5 r_clk = ~r_clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "global timeout");
    end

    // ---------------- memory model ----------------
    logic [DW-1:0] mem [8];
    always @(posedge r_clk) begin
        if (r_en) r_data <= mem[r_addr];
    end

    // ---------------- scoreboard / model state ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    int wptr;
    int m_rd, m_rd_prev, m_wbin_prev, m_buf, m_pend;
    int cnt_ren, cnt_pop, cyc, first_pop, last_pop;
    logic [AW:0] prev_gr;

    function automatic logic [AW:0] to_gray(input int b);
        logic [AW:0] v;
        v = AW'(0) + (AW+1)'(b & 15);
        return v ^ (v >> 1);
    endfunction

    function automatic int from_gray(input logic [AW:0] g);
        int b;
        b = 0;
        for (int i = AW; i >= 0; i--) begin
            b = b | ((((b >> (i + 1)) & 1) ^ int'(g[i])) << i);
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: model holds the state the DUT must show after the last edge.
    always @(negedge r_clk) begin
        logic exp_en, exp_valid, pop;
        cyc++;
        if (!r_rst_n) begin
            chk("rst_empty", 32'(empty), 32'd1);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_gr", 32'(gr_r_ptr), 32'd0);
            chk("rst_level", 32'(r_level), 32'd0);
            chk("rst_ren", 32'(r_en), 32'd0);
            m_rd = 0; m_rd_prev = 0; m_wbin_prev = 0; m_buf = 0; m_pend = 0;
            prev_gr = '0;
        end else begin
            exp_valid = (m_buf > 0);
            pop       = exp_valid && out_ready;
            exp_en    = ((m_rd & 15) != m_wbin_prev) && (m_buf + m_pend - int'(pop) < 2);
            chk("gr_ptr", 32'(gr_r_ptr), 32'(to_gray(m_rd)));
            chk("empty", 32'(empty), 32'((m_rd & 15) == m_wbin_prev));
            chk("level", 32'(r_level), 32'((m_wbin_prev - m_rd_prev) & 15));
            chk("level_bound", 32'(r_level <= 8), 32'd1);
            chk("valid", 32'(out_valid), 32'(exp_valid));
            chk("ren", 32'(r_en), 32'(exp_en));
            if (exp_en) chk("raddr", 32'(r_addr), 32'(m_rd & 7));
            if (exp_valid) begin
                if (exp_q.size() == 0) chk("sb_underrun", 32'd1, 32'd0);
                else chk("out_data", 32'(out_data), 32'(exp_q[0]));
            end
            if (gr_r_ptr !== prev_gr) chk("gray_step", 32'($countones(gr_r_ptr ^ prev_gr)), 32'd1);
            prev_gr = gr_r_ptr;
            if (r_en) cnt_ren++;
            if (pop) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_buf--;
                if (cnt_pop == 0) first_pop = cyc;
                last_pop = cyc;
                cnt_pop++;
            end
            if (m_pend != 0) m_buf++;
            m_pend      = int'(exp_en);
            m_rd_prev   = m_rd;
            m_rd        = m_rd + int'(exp_en);
            m_wbin_prev = from_gray(sync_gr_w_ptr);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic reset_dut();
        r_rst_n = 1'b0;
        wptr = 0;
        sync_gr_w_ptr = '0;
        exp_q.delete();
        repeat (3) tick();
        r_rst_n = 1'b1;
        cnt_ren = 0;
        cnt_pop = 0;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        int guard;
        guard = 0;
        while (wptr - m_rd >= 8 && guard < 50) begin
            out_ready = 1'b1;
            tick();
            guard++;
        end
        if (guard >= 50) chk("write_wait_timeout", 32'd1, 32'd0);
        mem[wptr & 7] = d;
        exp_q.push_back(d);
        wptr++;
    endtask

    task automatic publish();
        sync_gr_w_ptr = to_gray(wptr);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int guard;
        r_rst_n = 1'b0;
        out_ready = 1'b0;
        sync_gr_w_ptr = '0;
        wptr = 0;
        tick();

        // reset values
        reset_dut();
        chk("reset_done_empty", 32'(empty), 32'd1);
        chk("reset_done_valid", 32'(out_valid), 32'd0);
        chk("reset_done_gr", 32'(gr_r_ptr), 32'd0);

        // single word, out_valid three edges after the pointer change
        out_ready = 1'b1;
        write_word(8'hA5);
        publish();
        tick(); tick();
        chk("single_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'hA5);
        tick();
        chk("single_gone", 32'(out_valid), 32'd0);
        chk("single_gr", 32'(gr_r_ptr), 32'b0001);
        chk("single_empty", 32'(empty), 32'd1);
        chk("single_ren_cnt", 32'(cnt_ren), 32'd1);

        // burst of 8 with no bubbles
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) write_word(8'h10 + 8'(i));
        publish();
        repeat (14) tick();
        chk("burst_ren_cnt", 32'(cnt_ren), 32'd8);
        chk("burst_pop_cnt", 32'(cnt_pop), 32'd8);
        chk("burst_no_gaps", 32'(last_pop - first_pop), 32'd7);
        chk("burst_gr", 32'(gr_r_ptr), 32'b1100);
        chk("burst_empty", 32'(empty), 32'd1);

        // backpressure: only two reads leave memory
        reset_dut();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) write_word(8'h20 + 8'(i));
        publish();
        repeat (10) tick();
        chk("bp_ren_cnt", 32'(cnt_ren), 32'd2);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_head", 32'(out_data), 32'h20);
        out_ready = 1'b1;
        repeat (12) tick();
        chk("bp_pop_cnt", 32'(cnt_pop), 32'd8);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // wrap: 20 words through depth 8 with intermittent ready
        reset_dut();
        for (int i = 0; i < 20; i++) begin
            write_word(8'h40 + 8'(i));
            publish();
            out_ready = (i % 3 != 0);
            tick();
        end
        out_ready = 1'b1;
        guard = 0;
        while (cnt_pop < 20 && guard < 60) begin
            tick();
            guard++;
        end
        if (guard >= 60) chk("wrap_timeout", 32'd1, 32'd0);
        repeat (3) tick();
        chk("wrap_pop_cnt", 32'(cnt_pop), 32'd20);
        chk("wrap_gr", 32'(gr_r_ptr), 32'b0110);
        chk("wrap_empty", 32'(empty), 32'd1);

        // reset in the middle of a burst
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) write_word(8'h80 + 8'(i));
        publish();
        guard = 0;
        while (cnt_pop < 3 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) chk("midrst_timeout", 32'd1, 32'd0);
        r_rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_gr", 32'(gr_r_ptr), 32'd0);
        chk("midrst_level", 32'(r_level), 32'd0);
        chk("midrst_ren", 32'(r_en), 32'd0);
        wptr = 0;
        sync_gr_w_ptr = '0;
        exp_q.delete();
        tick(); tick();
        r_rst_n = 1'b1;
        cnt_pop = 0;
        repeat (4) tick();
        chk("midrst_no_stale", 32'(cnt_pop), 32'd0);
        write_word(8'hC3);
        publish();
        repeat (6) tick();
        chk("midrst_one_word", 32'(cnt_pop), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
